// File: rtl/ysyx_22050019_mem_pkg.sv
// rtl/ysyx_22050019_mem_pkg.sv - shared state encoding and lane constants for the data memory
package ysyx_22050019_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [63:0] DMEM_BASE  = 64'h8000_0000;
  localparam int unsigned LANE_W     = 3;
  localparam int unsigned BYTE_SHIFT = 3;
  localparam int unsigned CNT_W      = 4;

  // Byte lane to bit shift amount (lane * 8)
  function automatic logic [LANE_W+BYTE_SHIFT-1:0] lane_bits(input logic [LANE_W-1:0] lane);
    return {lane, {BYTE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/ysyx_22050019_dmem_array.sv
// rtl/ysyx_22050019_dmem_array.sv - DEPTH x 64 storage, byte-enable write, asynchronous read
module ysyx_22050019_dmem_array #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  input  logic [7:0]    wmask_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ysyx_22050019_dmem_resp.sv
// rtl/ysyx_22050019_dmem_resp.sv - fixed-latency data memory with request decode and error response
module ysyx_22050019_dmem_resp
  import ysyx_22050019_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = DMEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_re,
  input  logic [63:0] ram_raddr,
  input  logic        ram_we,
  input  logic [63:0] ram_waddr,
  input  logic [63:0] ram_wdata,
  input  logic [7:0]  wmask,
  output logic        req_ready,
  output logic [63:0] ram_rdata,
  output logic        rdata_valid,
  output logic        wr_done,
  output logic        err
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic [63:0]        addr_q;
  logic [63:0]        wdata_q;
  logic [7:0]         wmask_q;
  logic               rdata_valid_q;
  logic               wr_done_q;
  logic               err_q;
  logic [63:0]        rdata_q;

  logic [63:0]        off;
  logic [LANE_W-1:0]  lane;
  logic [AW-1:0]      idx;
  logic [15:0]        mask_wide;
  logic               req_err;
  logic               mem_we;
  logic [63:0]        mem_wdata;
  logic [7:0]         mem_wmask;
  logic [63:0]        rd_word;
  logic [63:0]        rdata_d;

  // Decode works on the latched request so WAIT/RESP ignore the live inputs
  always_comb begin
    off       = addr_q - BASE;
    lane      = addr_q[LANE_W-1:0];
    idx       = off[AW+2:3];
    mask_wide = {8'h00, wmask_q} << lane;
    req_err   = (addr_q < BASE) || (off >= 64'(8 * DEPTH)) ||
                (wr_q && (mask_wide[15:8] != 8'h00));
    mem_we    = (state_q == S_RESP) && wr_q && !req_err && !rst;
    mem_wdata = wdata_q << lane_bits(lane);
    mem_wmask = mask_wide[7:0];
    rdata_d   = req_err ? 64'h0 : (rd_word >> lane_bits(lane));
  end

  ysyx_22050019_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (idx),
    .wdata_i (mem_wdata),
    .wmask_i (mem_wmask),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= 64'h0;
    end else begin
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ram_we || ram_re) begin
            wr_q    <= ram_we;
            addr_q  <= ram_we ? ram_waddr : ram_raddr;
            wdata_q <= ram_wdata;
            wmask_q <= wmask;
            cnt_q   <= CNT_INIT;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          err_q   <= req_err;
          if (wr_q) begin
            wr_done_q <= 1'b1;
          end else begin
            rdata_valid_q <= 1'b1;
            rdata_q       <= rdata_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign ram_rdata   = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign wr_done     = wr_done_q;
  assign err         = err_q;

endmodule

// File: doc/ysyx_22050019_dmem_resp.md
YSYX_22050019_DMEM_RESP -- requirements
Module: ysyx_22050019_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 512: memory size in 64-bit words, power of two.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles between acceptance and response, legal range 1..15.
REQ-003 SHALL have parameter BASE, default 64'h8000_0000: byte address of word 0.
REQ-004 SHALL have port clk  input  1  single clock; every register updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports ram_re  input  1 (read request) and ram_raddr  input  64 (read byte address).
REQ-007 SHALL have ports ram_we  input  1 (write request), ram_waddr  input  64 (write byte address), ram_wdata  input  64 (write data, right-aligned) and wmask  input  8 (right-aligned byte enables).
REQ-008 SHALL have port req_ready  output  1: high when a request is accepted this cycle.
REQ-009 SHALL have ports ram_rdata  output  64 (read data, right-aligned) and rdata_valid  output  1 (read response strobe).
REQ-010 SHALL have port wr_done  output  1: write response strobe.
REQ-011 SHALL have port err  output  1: error flag, valid alongside rdata_valid or wr_done.

Function
REQ-012 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-013 SHALL assert req_ready only in IDLE.
REQ-014 SHALL accept a request in IDLE when ram_re or ram_we is high, latching address, wdata, wmask and op, and SHALL then enter WAIT.
REQ-015 SHALL give the write priority when ram_re and ram_we are both high at acceptance; the read is not accepted and must be held by the requester until the next IDLE.
REQ-016 SHALL load a counter with LATENCY-1 on entering WAIT, decrement it each cycle and enter RESP when it reaches 0.
REQ-017 SHALL make the response appear exactly LATENCY+1 cycles after the acceptance edge.
REQ-018 SHALL decode a request with off = addr-BASE, word index = off[log2(DEPTH)+2:3] and lane = addr[2:0].
REQ-019 SHALL shift write data and mask left by lane bytes and update only the enabled bytes at the RESP edge.
REQ-020 SHALL set ram_rdata to word>>(8*lane), zero-filled, when rdata_valid is high.
REQ-021 SHALL flag an error when addr<BASE, when off>=8*DEPTH, or when (wmask<<lane) carries past bit 7 (a write crossing an 8-byte boundary).
REQ-022 SHALL, on error, pulse err with the response strobe, leave memory unwritten and drive ram_rdata to 0.
REQ-023 SHALL, for reads, hold ram_rdata at the last value outside rdata_valid.
REQ-024 SHALL make rdata_valid and wr_done one-cycle pulses in RESP, never both high.
REQ-025 SHALL ignore ram_re and ram_we in WAIT and RESP.
REQ-026 SHALL have a read issued right after a write to the same word return the new data.

Reset
REQ-027 SHALL, with rst high at an edge, enter IDLE, clear the counter and drive req_ready=1, rdata_valid=0, wr_done=0, err=0 and ram_rdata=0 from the next cycle.
REQ-028 SHALL, on reset in WAIT or RESP, abort the transaction with no memory update and no strobe.
REQ-029 SHALL NOT clear memory contents on reset; the memory array is uninitialised.

Structure
REQ-030 SHALL keep the FSM state encoding, the BASE default and the lane-shift width constants in shared package ysyx_22050019_mem_pkg.
REQ-031 SHALL place the storage array (DEPTH x 64, byte-enable write, asynchronous read) in sub-module ysyx_22050019_dmem_array.
REQ-032 SHALL keep the FSM, counter, decode and error logic in the top module.

Verification
REQ-033 SHALL verify: write 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF -> wr_done at cycle 3 after acceptance; a read of the same address returns 0x1122334455667788.
REQ-034 SHALL verify: byte write 0x8000_0013, wdata 0xAB, wmask 0x01, then read 0x8000_0010 -> 0x11223344AB667788; read 0x8000_0013 -> low byte 0xAB.
REQ-035 SHALL verify: write 0x8000_0006, wmask 0x0F -> wr_done with err=1, memory unchanged; read 0x7FFF_FFF8 -> rdata_valid, err=1, rdata=0.
REQ-036 SHALL verify: ram_re and ram_we high together in IDLE -> write serviced first; read accepted on the next req_ready, 2*(LATENCY+2) cycles total.
REQ-037 SHALL verify: rst asserted during WAIT of a write -> no wr_done, target word unchanged, req_ready=1 the cycle after reset.
REQ-038 SHALL verify: LATENCY=1 back-to-back reads -> response at cycle 2 after each acceptance, req_ready low in WAIT and RESP.
